// File: rtl/alu_sel_pkg.sv
// alu_sel_pkg: select-width derivation, entry field widths and error-counter saturation for the ALU result selector.
// ALU_SEL_FLAGS_EN adds the zero/neg flag bits to each entry.
package alu_sel_pkg;
`ifdef ALU_SEL_FLAGS_EN
  localparam int FLAG_W = 2;
`else
  localparam int FLAG_W = 0;
`endif
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int entry_w(input int w, input int n);
    return FLAG_W + 1 + sel_w(n) + w;
  endfunction
  function automatic longint unsigned err_sat(input int cw);
    return (64'd1 << cw) - 64'd1;
  endfunction
endpackage

// File: rtl/alu_result_select_pipe_if.sv
// alu_result_select_pipe_if: upstream/downstream handshake bundle of the ALU result selector.
// ALU_SEL_FLAGS_EN adds out_zero/out_neg.
interface alu_result_select_pipe_if #(parameter int W = 32, parameter int N = 8, parameter int ERRCNT_W = 16);
  import alu_sel_pkg::*;
  localparam int SELW = sel_w(N);
  logic                in_valid;
  logic                in_ready;
  logic [SELW-1:0]     in_sel;
  logic [N*W-1:0]      in_data;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [SELW-1:0]     out_sel;
  logic                out_err;
  logic [ERRCNT_W-1:0] err_count;
`ifdef ALU_SEL_FLAGS_EN
  logic                out_zero;
  logic                out_neg;
  modport master (output in_valid, in_sel, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_sel, out_err, err_count, out_zero, out_neg);
  modport slave (input in_valid, in_sel, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_sel, out_err, err_count, out_zero, out_neg);
`else
  modport master (output in_valid, in_sel, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_sel, out_err, err_count);
  modport slave (input in_valid, in_sel, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_sel, out_err, err_count);
`endif
endinterface

// File: rtl/alu_sel_skid.sv
// alu_sel_skid: generic 2-entry skid buffer (head, skid, count); in_ready depends on registers only.
module alu_sel_skid #(parameter int EW = 8) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_entry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_entry
);
  logic [EW-1:0] head_q, head_d, skid_q, skid_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          accept, pop;
  assign in_ready  = !reset && cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_entry = head_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb begin
    head_d = (accept && (cnt_q == 2'd0 || pop)) ? in_entry : (pop && cnt_q == 2'd2) ? skid_q : head_q;
    skid_d = (accept && !pop && cnt_q == 2'd1) ? in_entry : skid_q;
    cnt_d  = cnt_q + {1'b0, accept} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_result_select_pipe.sv
// alu_result_select_pipe: N-input W-bit result selector with error tagging, saturating error count and skid-buffered output.
// ALU_SEL_FLAGS_EN adds per-entry zero/neg flags on out_zero/out_neg.
module alu_result_select_pipe
  import alu_sel_pkg::*;
#(
  parameter int W        = 32,
  parameter int N        = 8,
  parameter int ERRCNT_W = 16
) (
  input logic clk,
  input logic reset,
  alu_result_select_pipe_if.slave bus
);
  localparam int SELW = sel_w(N);
  localparam int EW   = entry_w(W, N);
  localparam logic [ERRCNT_W-1:0] ERR_MAX = ERRCNT_W'(err_sat(ERRCNT_W));
  logic [W-1:0]        opnd [2**SELW];
  logic [W-1:0]        data;
  logic                err, accept;
  logic [EW-1:0]       in_entry, out_entry;
  logic [ERRCNT_W-1:0] err_q, err_d;
  // Codes at or beyond N select a zero lane, so error entries carry data 0 for free.
  for (genvar g = 0; g < 2**SELW; g++) begin : g_lane
    if (g < N) begin : g_in
      assign opnd[g] = bus.in_data[g*W +: W];
    end else begin : g_pad
      assign opnd[g] = '0;
    end
  end
  assign data   = opnd[bus.in_sel];
  assign err    = {1'b0, bus.in_sel} >= (SELW+1)'(N);
  assign accept = bus.in_valid && bus.in_ready;
`ifdef ALU_SEL_FLAGS_EN
  assign in_entry = {data == '0, data[W-1], err, bus.in_sel, data};
  assign {bus.out_zero, bus.out_neg, bus.out_err, bus.out_sel, bus.out_data} = out_entry;
`else
  assign in_entry = {err, bus.in_sel, data};
  assign {bus.out_err, bus.out_sel, bus.out_data} = out_entry;
`endif
  assign bus.err_count = err_q;
  always_comb err_d = (accept && err && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else err_q <= err_d;
  end
  alu_sel_skid #(.EW(EW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_entry  (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_entry (out_entry)
  );
endmodule

// File: tb/tb_alu_result_select_pipe.sv
// tb_alu_result_select_pipe: directed table, corner sequences and queue-model random test on N=8 and N=6/ERRCNT_W=2 instances.
module tb_alu_result_select_pipe;
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] d;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    bit          exp_e1;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
    bit          e;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  alu_result_select_pipe_if #(.W(32), .N(8), .ERRCNT_W(16)) b0 ();
  alu_result_select_pipe_if #(.W(32), .N(6), .ERRCNT_W(2)) b1 ();
  alu_result_select_pipe #(.W(32), .N(8), .ERRCNT_W(16)) dut0 (.clk(clk), .reset(rst), .bus(b0));
  alu_result_select_pipe #(.W(32), .N(6), .ERRCNT_W(2)) dut1 (.clk(clk), .reset(rst), .bus(b1));
  logic z0, g0, z1, g1;
`ifdef ALU_SEL_FLAGS_EN
  assign z0 = b0.out_zero;
  assign g0 = b0.out_neg;
  assign z1 = b1.out_zero;
  assign g1 = b1.out_neg;
`else
  assign z0 = 1'b0;
  assign g0 = 1'b0;
  assign z1 = 1'b0;
  assign g1 = 1'b0;
`endif
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_flags(input string nm, input logic z, input logic g, input logic [31:0] d);
`ifdef ALU_SEL_FLAGS_EN
    chk({nm, " zero"}, z, d == 32'd0);
    chk({nm, " neg"}, g, d[31]);
`endif
  endtask
  task automatic drive(input bit v0, input bit r0, input bit v1, input bit r1,
                       input logic [2:0] s, input logic [7:0][31:0] w);
    b0.in_valid = v0;
    b0.out_ready = r0;
    b1.in_valid = v1;
    b1.out_ready = r1;
    b0.in_sel = s;
    b1.in_sel = s;
    b0.in_data = w;
    b1.in_data = w[5:0];
  endtask
  function automatic logic [7:0][31:0] rnd_words();
    logic [7:0][31:0] w;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    return w;
  endfunction
  task automatic cmp(input string nm, input int sz, input exp_t h, input int ec_exp,
                     input logic ir, input logic ov, input logic [31:0] od, input logic [2:0] os,
                     input logic oe, input int ec, input logic z, input logic g);
    chk({nm, " in_ready"}, ir, sz < 2);
    chk({nm, " out_valid"}, ov, sz > 0);
    if (sz > 0) begin
      chk({nm, " out_data"}, od, h.d);
      chk({nm, " out_sel"}, os, h.s);
      chk({nm, " out_err"}, oe, h.e);
      chk_flags(nm, z, g, h.d);
    end
    chk({nm, " err_count"}, ec, ec_exp);
  endtask
  initial begin
    vec_t             tbl [6];
    logic [7:0][31:0] w;
    logic [31:0]      d1, d2, pd;
    logic [2:0]       ps;
    int               e1;
    exp_t             q0 [$];
    exp_t             q1 [$];
    exp_t             h0, h1;
    int               ec0, ec1;
    bit               v, r;
    logic [2:0]       s;
    tbl[0] = '{3'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{3'd7, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
    tbl[2] = '{3'd0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    tbl[3] = '{3'd5, 32'h80000001, 32'h80000001, 32'h80000001, 1'b0};
    tbl[4] = '{3'd6, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 1'b1};
    tbl[5] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
    w = '0;
    drive(0, 0, 0, 0, 3'd0, w);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset in_ready", b0.in_ready, 0);
    chk("reset out_valid", b0.out_valid, 0);
    chk("reset out_data", b0.out_data, 0);
    chk("reset out_sel", b0.out_sel, 0);
    chk("reset out_err", b0.out_err, 0);
    chk("reset err_count", b0.err_count, 0);
    chk_flags("reset", z0, g0, 32'h1);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", b0.in_ready, 1);
    chk("post-reset out_valid", b0.out_valid, 0);
    e1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w = rnd_words();
      w[tbl[i].sel] = tbl[i].d;
      drive(1, 1, 1, 1, tbl[i].sel, w);
      if (tbl[i].exp_e1 && e1 < 3) e1++;
      @(negedge clk);
      drive(0, 1, 0, 1, 3'd0, w);
      chk("tbl n8 out_valid", b0.out_valid, 1);
      chk("tbl n8 out_data", b0.out_data, tbl[i].exp_d0);
      chk("tbl n8 out_sel", b0.out_sel, tbl[i].sel);
      chk("tbl n8 out_err", b0.out_err, 0);
      chk("tbl n8 err_count", b0.err_count, 0);
      chk_flags("tbl n8", z0, g0, tbl[i].exp_d0);
      chk("tbl n6 out_valid", b1.out_valid, 1);
      chk("tbl n6 out_data", b1.out_data, tbl[i].exp_d1);
      chk("tbl n6 out_sel", b1.out_sel, tbl[i].sel);
      chk("tbl n6 out_err", b1.out_err, tbl[i].exp_e1);
      chk("tbl n6 err_count", b1.err_count, e1);
      chk_flags("tbl n6", z1, g1, tbl[i].exp_d1);
    end
    @(negedge clk);
    w = rnd_words();
    d1 = w[1];
    drive(1, 0, 0, 1, 3'd1, w);
    @(negedge clk);
    w = rnd_words();
    d2 = w[2];
    drive(1, 0, 0, 1, 3'd2, w);
    @(negedge clk);
    chk("bp full in_ready", b0.in_ready, 0);
    chk("bp full out_valid", b0.out_valid, 1);
    chk("bp head sel", b0.out_sel, 1);
    chk("bp head data", b0.out_data, d1);
    drive(0, 0, 0, 1, 3'd0, w);
    @(negedge clk);
    chk("bp hold sel", b0.out_sel, 1);
    chk("bp hold data", b0.out_data, d1);
    drive(0, 1, 0, 1, 3'd0, w);
    @(negedge clk);
    chk("bp second in_ready", b0.in_ready, 1);
    chk("bp second out_valid", b0.out_valid, 1);
    chk("bp second sel", b0.out_sel, 2);
    chk("bp second data", b0.out_data, d2);
    @(negedge clk);
    chk("bp drained out_valid", b0.out_valid, 0);
    pd = '0;
    ps = '0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("stream out_valid", b0.out_valid, 1);
        chk("stream out_data", b0.out_data, pd);
        chk("stream out_sel", b0.out_sel, ps);
        chk("stream in_ready", b0.in_ready, 1);
      end
      w = rnd_words();
      ps = 3'(c % 8);
      pd = w[ps];
      if (c < 20) drive(1, 1, 0, 1, ps, w);
      else drive(0, 1, 0, 1, 3'd0, w);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 1, 1, 1, 3'd7, rnd_words());
    end
    @(negedge clk);
    drive(0, 1, 0, 1, 3'd0, w);
    chk("sat err_count", b1.err_count, 3);
    chk("sat out_err", b1.out_err, 1);
    chk("sat out_data", b1.out_data, 0);
    chk("sat n8 err_count", b0.err_count, 0);
    @(negedge clk);
    drive(1, 0, 0, 1, 3'd4, rnd_words());
    @(negedge clk);
    drive(1, 0, 0, 1, 3'd5, rnd_words());
    @(negedge clk);
    drive(0, 0, 0, 1, 3'd0, w);
    chk("midrst full in_ready", b0.in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", b0.out_valid, 0);
    chk("midrst in_ready low", b0.in_ready, 0);
    chk("midrst n6 err_count", b1.err_count, 0);
    chk("midrst out_data", b0.out_data, 0);
    rst = 1'b0;
    #1;
    chk("midrst in_ready", b0.in_ready, 1);
    ec0 = 0;
    ec1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      h0 = (q0.size() > 0) ? q0[0] : '{32'd0, 3'd0, 1'b0};
      h1 = (q1.size() > 0) ? q1[0] : '{32'd0, 3'd0, 1'b0};
      cmp("rnd n8", q0.size(), h0, ec0, b0.in_ready, b0.out_valid, b0.out_data, b0.out_sel,
          b0.out_err, int'(b0.err_count), z0, g0);
      cmp("rnd n6", q1.size(), h1, ec1, b1.in_ready, b1.out_valid, b1.out_data, b1.out_sel,
          b1.out_err, int'(b1.err_count), z1, g1);
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      s = 3'($urandom_range(0, 7));
      w = rnd_words();
      if ($urandom_range(0, 5) == 0) w[s] = 32'd0;
      drive(v, r, v, r, s, w);
      @(posedge clk);
      if (v && q0.size() < 2) begin
        if (r && q0.size() > 0) void'(q0.pop_front());
        q0.push_back('{w[s], s, 1'b0});
      end else if (r && q0.size() > 0) void'(q0.pop_front());
      if (v && q1.size() < 2) begin
        if (r && q1.size() > 0) void'(q1.pop_front());
        q1.push_back('{(s < 6) ? w[s] : 32'd0, s, s >= 6});
        if (s >= 6 && ec1 < 3) ec1++;
      end else if (r && q1.size() > 0) void'(q1.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_select_pipe.md
Name: alu_result_select_pipe

Overview:
Parametrised N-input, W-bit result selector for the vALU datapath, with a registered output stage and a valid/ready handshake. It selects one operation result per accepted transaction, tags it with the select code and an out-of-range error, and holds it in a 2-entry skid buffer. The ALU result path can therefore be pipelined without combinational backpressure. It sits between the per-operation units (adder, logic, shifter, SLT) and the writeback/flags logic.

Parameters:
W, 32, data width of each input and of the output
N, 8, number of result inputs (2..16, need not be a power of two)
SELW, max(1, clog2(N)), select width (derived, not overridden)
ERRCNT_W, 16, width of saturating error counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  upstream offers a transaction
in_ready  output  1  block can accept this cycle
in_sel  input  SELW  select code; input i is in_data[i*W +: W]
in_data  input  N*W  flattened result inputs, input 0 at LSBs
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head
out_data  output  W  selected result of head entry
out_sel  output  SELW  select code of head entry
out_err  output  1  head entry had in_sel >= N
err_count  output  ERRCNT_W  saturating count of accepted out-of-range selects

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Entry = {err, sel, data}. data = in_data[in_sel*W +: W] if in_sel < N. Otherwise data = 0 and err = 1.
- Storage: head register, skid register, and a count register (0..2).
- in_ready = !reset && (count != 2). It depends on registers only; there is no combinational path from out_ready.
- out_valid = (count != 0). out_data, out_sel and out_err always come from the head register.
- Latency: an entry accepted at edge k is visible on the outputs after edge k, if the buffer was empty or popped at edge k.
- Transitions:
  - count 0, accept: head <= new, count 1.
  - count 1, accept only: skid <= new, count 2.
  - count 1, pop only: count 0.
  - count 1, accept and pop: head <= new, count stays 1.
  - count 2, pop: head <= skid, count 1.
  - count 2 with accept is impossible (in_ready = 0).
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Holding: while out_valid && !out_ready, out_data, out_sel and out_err are stable.
- Reset:
  - Values: count 0, out_valid 0, head and skid 0 (out_data 0, out_sel 0, out_err 0), err_count 0, in_ready 0 while reset is high.
  - Mid-operation: in-flight entries are discarded; no pop is reported.
- Error counter: err_count increments on each accept with in_sel >= N and saturates at 2^ERRCNT_W-1 (does not wrap).
- Power-of-two N: when N = 2^SELW, err is never set.

Optional Feature:
Macro ALU_SEL_FLAGS_EN.
- Defined: adds ports out_zero (1 bit) and out_neg (1 bit). These are computed at accept time from the selected data: zero = (data == 0) and neg = data[W-1]. They are stored per entry and follow head exactly like out_data. An error entry reports zero = 1 and neg = 0. Reset value 0 for both.
- Undefined: these ports and their storage do not exist; all other behaviour is identical.

Decomposition:
- Package alu_sel_pkg: the SELW derivation function (clog2 with minimum 1), the entry field-width constants, and the error-counter saturation value.
- Sub-module alu_sel_skid: the generic 2-entry skid buffer, parametrised by entry width, holding head, skid and count.
- The top level does the selection, error/flag formation and err_count, then packs the entry into alu_sel_skid.

Test Plan:
- Reset and single accept: hold reset, then release; in_ready = 1, out_valid = 0. Send in_sel = 3 with in_data[3*32 +: 32] = 0xDEADBEEF. Next cycle: out_valid = 1, out_data = 0xDEADBEEF, out_sel = 3, out_err = 0.
- Backpressure and ordering: out_ready = 0, send sel 1 then sel 2. Expect count 2 and in_ready = 0 on the third cycle. Release out_ready; outputs are sel 1 then sel 2 with the correct data, and no loss.
- Streaming: out_ready = 1 and in_valid = 1 for 20 cycles with sel = cycle mod 8. Expect one output per cycle, in_ready held at 1, data matching in order.
- Out of range: N = 6, in_sel = 7. Expect out_data = 0, out_err = 1, err_count = 1. Then force ERRCNT_W = 2 and send 5 errors; err_count saturates at 3.
- Reset mid-operation: fill 2 entries, assert reset for 1 cycle. Next cycle: out_valid = 0, err_count = 0, and in_ready = 1 after reset deasserts.
- Flags (ALU_SEL_FLAGS_EN): select 0x00000000, expect out_zero = 1 and out_neg = 0. Select 0x80000001, expect out_zero = 0 and out_neg = 1.
